btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter N, default 3, number of independent button channels (1..16).
REQ-002 Parameter DB_CYCLES, default 2_000_000, stable-input cycles required to accept a level change (20 ms at 100 MHz); minimum 2.
REQ-003 Parameter REP_DELAY, default 50_000_000, hold cycles before the first auto-repeat tick; used only with the macro of REQ-027.
REQ-004 Parameter REP_PERIOD, default 10_000_000, cycles between subsequent auto-repeat ticks; used only with the macro of REQ-027.
REQ-005 clk  input  1  sole clock, rising-edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 btn_raw  input  N  raw, asynchronous, bouncing button levels, 1 = pressed.
REQ-008 btn_db  output  N  debounced level per channel.
REQ-009 rise_tick  output  N  one-cycle pulse per accepted press.
REQ-010 fall_tick  output  N  one-cycle pulse per accepted release.
REQ-011 rep_tick  output  N  one-cycle auto-repeat pulse; tied to 0 without the macro of REQ-027.

Function
REQ-012 Each channel shall pass btn_raw[i] through a two-flop synchronizer; s[i] denotes the second flop output.
REQ-013 Each channel shall run an independent FSM with states ZERO, WAIT1, ONE and WAIT0, plus its own counter wide enough for max(DB_CYCLES, REP_DELAY, REP_PERIOD).
REQ-014 ZERO: if s=1, go to WAIT1 with counter=0; otherwise stay.
REQ-015 WAIT1: if s=0, return to ZERO; else if counter=DB_CYCLES-1, go to ONE; else increment counter.
REQ-016 ONE: if s=0, go to WAIT0 with counter=0; otherwise stay.
REQ-017 WAIT0: if s=1, return to ONE; else if counter=DB_CYCLES-1, go to ZERO; else increment counter.
REQ-018 btn_db[i] shall be 1 in states ONE and WAIT0 and 0 in states ZERO and WAIT1 (registered output).
REQ-019 rise_tick[i] shall be 1 for exactly the first cycle in which btn_db[i] is 1; fall_tick[i] shall be 1 for exactly the first cycle in which btn_db[i] is 0 after being 1.
REQ-020 A bounce shorter than DB_CYCLES cycles shall produce no change on btn_db, rise_tick or fall_tick.
REQ-021 Latency: with btn_raw held steady from a change onward, btn_db shall change DB_CYCLES+3 rising edges after the first edge that samples the new value.
REQ-022 Channels shall be fully independent; simultaneous events on several channels shall produce simultaneous ticks.
REQ-023 rise_tick and fall_tick on the same channel shall never be asserted in the same cycle.

Reset
REQ-024 While reset=1, all FSMs shall be in ZERO, counters and synchronizers shall be 0, and btn_db, rise_tick, fall_tick and rep_tick shall all be 0, regardless of clk.
REQ-025 A button held through reset release shall be treated as a new press: rise_tick fires DB_CYCLES+3 edges after release.
REQ-026 Reset asserted mid-debounce shall abort that debounce without emitting any tick.

Configuration
REQ-027 With macro BTN_COND_AUTOREPEAT_EN defined:
- In ONE, the counter counts hold cycles.
- rep_tick[i] pulses once when the hold reaches REP_DELAY cycles after the rise_tick cycle, then once every REP_PERIOD cycles while the FSM remains in ONE.
- Entering WAIT0 stops repeats; returning to ONE from WAIT0 restarts the REP_DELAY interval.
REQ-028 Without BTN_COND_AUTOREPEAT_EN, rep_tick shall be constant 0 and no repeat logic shall be synthesized.

Verification (DB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3, N=3)
REQ-029 Apply reset, then btn_raw=000 -> all outputs 0; btn_raw[0] steps to 1 -> btn_db[0] rises 7 edges later, with rise_tick[0] high for exactly one cycle.
REQ-030 btn_raw[1] toggles 1,0,1,0 with 2-cycle high/low periods, then stays 0 -> btn_db[1] stays 0 and no ticks are emitted.
REQ-031 Hold btn_raw[2]=1 until btn_db[2]=1, then bounce low for 3 cycles, then release for good -> fall_tick[2] fires exactly once, 7 edges after the final release.
REQ-032 Step btn_raw to 111 in one cycle -> rise_tick is 111 in a single cycle; assert reset mid-debounce in a second run -> no tick is emitted.
REQ-033 BTN_COND_AUTOREPEAT_EN defined, hold btn_raw[0]=1 for 30 cycles after rise_tick -> rep_tick[0] pulses at +10, +13, +16, ... cycles; without the macro, rep_tick stays 000.

Source files
------------

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Purpose:
//   Conditions N raw mechanical push-buttons. Each channel is synchronized
//   into the clk domain, debounced by a four-state FSM that demands
//   DB_CYCLES stable cycles before accepting a level change, and produces
//   one-cycle press/release pulses. An optional auto-repeat generator emits
//   periodic pulses while a button is held.
//
// Configuration macro:
//   BTN_COND_AUTOREPEAT_EN - when defined, rep_tick pulses REP_DELAY cycles
//                            after a press and then every REP_PERIOD cycles
//                            while held. When undefined, rep_tick is tied to 0
//                            and no repeat logic exists.
//
// Ports:
//   clk        in   1   sole clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   btn_raw    in   N   raw asynchronous button levels, 1 = pressed
//   btn_db     out  N   debounced level per channel
//   rise_tick  out  N   one-cycle pulse per accepted press
//   fall_tick  out  N   one-cycle pulse per accepted release
//   rep_tick   out  N   one-cycle auto-repeat pulse (0 without the macro)
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int N          = 3,
  parameter int DB_CYCLES  = 2_000_000,
  parameter int REP_DELAY  = 50_000_000,
  parameter int REP_PERIOD = 10_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_db,
  output logic [N-1:0] rise_tick,
  output logic [N-1:0] fall_tick,
  output logic [N-1:0] rep_tick
);

  // One counter width serves debounce and repeat timing.
  localparam int MAX_AB = (DB_CYCLES > REP_DELAY) ? DB_CYCLES : REP_DELAY;
  localparam int MAX_C  = (MAX_AB > REP_PERIOD) ? MAX_AB : REP_PERIOD;
  localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C + 1) : 1;

  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  logic [N-1:0] sync1;
  logic [N-1:0] sync2;

  // Two-flop synchronizer on every raw input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifndef BTN_COND_AUTOREPEAT_EN
  assign rep_tick = '0;
`endif

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          db_q;
    logic          db_next;
    logic          rise_q;
    logic          fall_q;
    logic          s;

    assign s = sync2[i];

`ifdef BTN_COND_AUTOREPEAT_EN
    localparam logic [CW-1:0] DLY_LAST = CW'(REP_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REP_PERIOD - 1);

    logic repeating;
    logic repeating_next;
    logic rep_q;
    logic rep_next;
`endif

    // State, counter and registered outputs. Ticks compare the next debounced
    // level against the current one so they coincide with the level change.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state  <= ZERO;
        cnt    <= '0;
        db_q   <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
`ifdef BTN_COND_AUTOREPEAT_EN
        repeating <= 1'b0;
        rep_q     <= 1'b0;
`endif
      end else begin
        state  <= state_next;
        cnt    <= cnt_next;
        db_q   <= db_next;
        rise_q <= db_next & ~db_q;
        fall_q <= ~db_next & db_q;
`ifdef BTN_COND_AUTOREPEAT_EN
        repeating <= repeating_next;
        rep_q     <= rep_next;
`endif
      end
    end

    // Debounce FSM. In ONE the counter is reused as the hold timer for
    // auto-repeat; 'repeating' selects between the initial delay and the
    // repeat period as the terminal count.
    always_comb begin
      state_next = state;
      cnt_next   = cnt;
`ifdef BTN_COND_AUTOREPEAT_EN
      repeating_next = repeating;
      rep_next       = 1'b0;
`endif
      case (state)
        ZERO: begin
          if (s) begin
            state_next = WAIT1;
            cnt_next   = '0;
          end
        end
        WAIT1: begin
          if (!s) begin
            state_next = ZERO;
          end else if (cnt == DB_LAST) begin
            state_next = ONE;
            cnt_next   = '0;
`ifdef BTN_COND_AUTOREPEAT_EN
            repeating_next = 1'b0;
`endif
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        ONE: begin
          if (!s) begin
            state_next = WAIT0;
            cnt_next   = '0;
          end else begin
`ifdef BTN_COND_AUTOREPEAT_EN
            if (cnt == (repeating ? PER_LAST : DLY_LAST)) begin
              rep_next       = 1'b1;
              repeating_next = 1'b1;
              cnt_next       = '0;
            end else begin
              cnt_next = cnt + CW'(1);
            end
`endif
          end
        end
        WAIT0: begin
          if (s) begin
            state_next = ONE;
            cnt_next   = '0;
`ifdef BTN_COND_AUTOREPEAT_EN
            repeating_next = 1'b0;
`endif
          end else if (cnt == DB_LAST) begin
            state_next = ZERO;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        default: begin
          state_next = ZERO;
          cnt_next   = '0;
        end
      endcase
      db_next = (state_next == ONE) || (state_next == WAIT0);
    end

    assign btn_db[i]    = db_q;
    assign rise_tick[i] = rise_q;
    assign fall_tick[i] = fall_q;
`ifdef BTN_COND_AUTOREPEAT_EN
    assign rep_tick[i]  = rep_q;
`endif
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//
// Purpose:
//   Self-checking bench for btn_conditioner with DB_CYCLES=4, REP_DELAY=10,
//   REP_PERIOD=3, N=3. A behavioural model tracks each channel as "the
//   synchronized level must disagree with the debounced level for DB_CYCLES+1
//   consecutive samples before it flips"; hold time since press drives the
//   expected repeat pulses. Honors BTN_COND_AUTOREPEAT_EN like the design.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

  localparam int N  = 3;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef BTN_COND_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_db;
  logic [N-1:0] rise_tick;
  logic [N-1:0] fall_tick;
  logic [N-1:0] rep_tick;

  int n_checks;
  int n_fail;

  // Model state
  bit [N-1:0] p1, p2, edb, erise, efall, erep;
  int         mcnt  [N];
  int         mhold [N];

  btn_conditioner #(
    .N(N), .DB_CYCLES(DB), .REP_DELAY(RD), .REP_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_db(btn_db),
    .rise_tick(rise_tick), .fall_tick(fall_tick), .rep_tick(rep_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, update the model with the level sampled on that
  // edge, then settle 1 time unit so the caller samples away from the edge.
  task automatic tick();
    bit s;
    @(posedge clk);
    erise = '0;
    efall = '0;
    erep  = '0;
    if (reset) begin
      p1 = '0; p2 = '0; edb = '0;
      for (int i = 0; i < N; i++) begin
        mcnt[i] = 0; mhold[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        s = p2[i];
        p2[i] = p1[i];
        p1[i] = btn_raw[i];
        if (s != edb[i]) begin
          mcnt[i]++;
          if (mcnt[i] == DB + 1) begin
            edb[i]  = ~edb[i];
            mcnt[i] = 0;
            if (edb[i]) begin
              erise[i] = 1'b1;
              mhold[i] = 0;
            end else begin
              efall[i] = 1'b1;
            end
          end
        end else if (edb[i]) begin
          if (mcnt[i] > 0) begin
            mcnt[i]  = 0;
            mhold[i] = 0;
          end else begin
            mhold[i]++;
            if (AR && mhold[i] >= RD && ((mhold[i] - RD) % RP) == 0)
              erep[i] = 1'b1;
          end
        end else begin
          mcnt[i] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reset clears everything; a button held through release is a new press.
  task automatic test_reset();
    int k;
    reset   = 1'b1;
    btn_raw = 3'b111;
    #3;
    n_checks++;
    if ({btn_db, rise_tick, fall_tick, rep_tick} !== 12'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_async: got %b want 0", {btn_db, rise_tick, fall_tick, rep_tick});
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      btn_raw = 3'($urandom);
      n_checks++;
      if ({btn_db, rise_tick, fall_tick, rep_tick} !== 12'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_held c=%0d: got %b want 0", c, {btn_db, rise_tick, fall_tick, rep_tick});
      end
    end
    btn_raw = 3'b001;
    tick();
    reset = 1'b0;
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      n_checks++;
      if ({btn_db, rise_tick, fall_tick, rep_tick} !== {edb, erise, efall, erep}) begin
        n_fail++;
        $display("[TB] FAIL reset_release_model c=%0d: got %b want %b", c,
                 {btn_db, rise_tick, fall_tick, rep_tick}, {edb, erise, efall, erep});
      end
      if (rise_tick[0] && k == 0) k = c;
    end
    n_checks++;
    if (k != DB + 3) begin
      n_fail++;
      $display("[TB] FAIL reset_release_latency: got %0d want %0d", k, DB + 3);
    end
    do_reset();
    btn_raw = 3'b000;
  endtask

  // Clean press on channel 0: level after DB+3 edges, one rise tick.
  task automatic test_press();
    int k, rises;
    btn_raw = 3'b000;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if ({btn_db, rise_tick, fall_tick, rep_tick} !== 12'b0) begin
        n_fail++;
        $display("[TB] FAIL press_idle c=%0d: got %b want 0", c, {btn_db, rise_tick, fall_tick, rep_tick});
      end
    end
    btn_raw[0] = 1'b1;
    k = 0;
    rises = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      n_checks++;
      if ({btn_db, rise_tick, fall_tick, rep_tick} !== {edb, erise, efall, erep}) begin
        n_fail++;
        $display("[TB] FAIL press_model c=%0d: got %b want %b", c,
                 {btn_db, rise_tick, fall_tick, rep_tick}, {edb, erise, efall, erep});
      end
      if (rise_tick[0]) rises++;
      if (btn_db[0] && k == 0) k = c;
    end
    n_checks++;
    if (k != DB + 3) begin
      n_fail++;
      $display("[TB] FAIL press_latency: got %0d want %0d", k, DB + 3);
    end
    n_checks++;
    if (rises != 1) begin
      n_fail++;
      $display("[TB] FAIL press_rise_count: got %0d want 1", rises);
    end
    btn_raw[0] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_checks++;
      if ({btn_db, rise_tick, fall_tick, rep_tick} !== {edb, erise, efall, erep}) begin
        n_fail++;
        $display("[TB] FAIL press_release_model c=%0d: got %b want %b", c,
                 {btn_db, rise_tick, fall_tick, rep_tick}, {edb, erise, efall, erep});
      end
    end
  endtask

  // Short bounces on channel 1 never reach the output.
  task automatic test_bounce();
    bit pattern [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    for (int c = 0; c < 20; c++) begin
      btn_raw[1] = (c < 8) ? pattern[c] : 1'b0;
      tick();
      n_checks++;
      if ({btn_db[1], rise_tick[1], fall_tick[1]} !== 3'b000 ||
          {btn_db, rise_tick, fall_tick, rep_tick} !== {edb, erise, efall, erep}) begin
        n_fail++;
        $display("[TB] FAIL bounce c=%0d: got %b want %b", c,
                 {btn_db, rise_tick, fall_tick, rep_tick}, {edb, erise, efall, erep});
      end
    end
  endtask

  // Release with a short low glitch first: exactly one fall, DB+3 edges after
  // the final release.
  task automatic test_release_bounce();
    int falls, k, c;
    btn_raw[2] = 1'b1;
    c = 0;
    while (!btn_db[2] && c < 20) begin
      tick();
      c++;
    end
    n_checks++;
    if (!btn_db[2]) begin
      n_fail++;
      $display("[TB] FAIL relb_press_timeout: got db=%b want 1", btn_db[2]);
    end
    falls = 0;
    k = 0;
    for (int j = 0; j < 26; j++) begin
      if (j < 3)      btn_raw[2] = 1'b0;
      else if (j < 6) btn_raw[2] = 1'b1;
      else            btn_raw[2] = 1'b0;
      tick();
      n_checks++;
      if ({btn_db, rise_tick, fall_tick, rep_tick} !== {edb, erise, efall, erep}) begin
        n_fail++;
        $display("[TB] FAIL relb_model j=%0d: got %b want %b", j,
                 {btn_db, rise_tick, fall_tick, rep_tick}, {edb, erise, efall, erep});
      end
      if (fall_tick[2]) begin
        falls++;
        if (k == 0) k = j - 5;
      end
    end
    n_checks++;
    if (falls != 1 || k != DB + 3) begin
      n_fail++;
      $display("[TB] FAIL relb_fall: got count=%0d at=%0d want count=1 at=%0d", falls, k, DB + 3);
    end
  endtask

  // All channels pressed together tick together; reset mid-debounce aborts.
  task automatic test_simultaneous();
    logic [N-1:0] seen;
    seen = '0;
    btn_raw = 3'b111;
    for (int c = 1; c <= 12; c++) begin
      tick();
      n_checks++;
      if ({btn_db, rise_tick, fall_tick, rep_tick} !== {edb, erise, efall, erep}) begin
        n_fail++;
        $display("[TB] FAIL simul_model c=%0d: got %b want %b", c,
                 {btn_db, rise_tick, fall_tick, rep_tick}, {edb, erise, efall, erep});
      end
      if (rise_tick != '0 && seen == '0) seen = rise_tick;
    end
    n_checks++;
    if (seen !== 3'b111) begin
      n_fail++;
      $display("[TB] FAIL simul_rise: got %b want 111", seen);
    end
    btn_raw = 3'b000;
    for (int c = 0; c < 12; c++) tick();
    btn_raw = 3'b111;
    for (int c = 0; c < 4; c++) tick();
    reset = 1'b1;
    #1;
    btn_raw = 3'b000;
    n_checks++;
    if ({btn_db, rise_tick, fall_tick, rep_tick} !== 12'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_async: got %b want 0", {btn_db, rise_tick, fall_tick, rep_tick});
    end
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick();
      n_checks++;
      if ({btn_db, rise_tick, fall_tick, rep_tick} !== 12'b0) begin
        n_fail++;
        $display("[TB] FAIL midreset_quiet c=%0d: got %b want 0", c, {btn_db, rise_tick, fall_tick, rep_tick});
      end
    end
  endtask

  // Auto-repeat timing on channel 0 (or silence without the feature).
  task automatic test_autorepeat();
    int c;
    bit want;
    btn_raw = 3'b001;
    c = 0;
    while (!rise_tick[0] && c < 20) begin
      tick();
      c++;
    end
    n_checks++;
    if (!rise_tick[0]) begin
      n_fail++;
      $display("[TB] FAIL rep_rise_timeout: got %b want 1", rise_tick[0]);
    end
    for (int k = 1; k <= 30; k++) begin
      tick();
      want = AR && k >= RD && ((k - RD) % RP) == 0;
      n_checks++;
      if (rep_tick !== {2'b00, want} ||
          {btn_db, rise_tick, fall_tick, rep_tick} !== {edb, erise, efall, erep}) begin
        n_fail++;
        $display("[TB] FAIL rep_timing k=%0d: got rep=%b all=%b want rep=%b all=%b", k, rep_tick,
                 {btn_db, rise_tick, fall_tick, rep_tick}, {2'b00, want}, {edb, erise, efall, erep});
      end
    end
    btn_raw = 3'b000;
    for (int k = 0; k < 12; k++) tick();
  endtask

  // Random bouncing on all channels against the model.
  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) btn_raw[i] = ~btn_raw[i];
      tick();
      n_checks++;
      if ({btn_db, rise_tick, fall_tick, rep_tick} !== {edb, erise, efall, erep} ||
          (rise_tick & fall_tick) !== '0) begin
        n_fail++;
        $display("[TB] FAIL random c=%0d: got %b want %b", c,
                 {btn_db, rise_tick, fall_tick, rep_tick}, {edb, erise, efall, erep});
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    btn_raw  = '0;
    test_reset();
    test_press();
    test_bounce();
    test_release_bounce();
    btn_raw = '0;
    for (int c = 0; c < 12; c++) tick();
    test_simultaneous();
    test_autorepeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
